// File: rtl/pwm_multichannel_if.sv
// Duty-register write bus between the SPI register file and the PWM block.
// The master drives a one-cycle write strobe together with a channel index
// and the duty value destined for that channel's shadow register.
interface pwm_multichannel_if #(
    parameter int NUM_CH = 16,
    parameter int CNT_W  = 8
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic             duty_wr_en;
    logic [CH_W-1:0]  duty_wr_ch;
    logic [CNT_W-1:0] duty_wr_data;

    modport master (
        output duty_wr_en,
        output duty_wr_ch,
        output duty_wr_data
    );

    modport slave (
        input duty_wr_en,
        input duty_wr_ch,
        input duty_wr_data
    );
endinterface

// File: rtl/pwm_multichannel.sv
// N-channel PWM generator with a shared prescaler and period counter.
// Every channel has a shadow duty register written from the bus and an
// active duty register that is reloaded only at a counter wrap, so duty
// changes never cut a PWM period short or produce a runt pulse.
module pwm_multichannel #(
    parameter int NUM_CH  = 16,
    parameter int CNT_W   = 8,
    parameter int PRESC_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    pwm_multichannel_if.slave   duty_bus,
    input  logic [NUM_CH-1:0]   en_out,
    input  logic [NUM_CH-1:0]   en_pwm,
    input  logic [PRESC_W-1:0]  prescale,
    input  logic [CNT_W-1:0]    period,
    output logic [NUM_CH-1:0]   out,
    output logic                period_start
);

    logic [PRESC_W-1:0] presc_cnt;
    logic [CNT_W-1:0]   cnt;
    logic [CNT_W-1:0]   shadow [NUM_CH];
    logic [CNT_W-1:0]   active [NUM_CH];
    logic               tick;
    logic               wrap;
    logic               wr_valid;
    logic [31:0]        wr_ch_ext;
    logic [NUM_CH-1:0]  hi;

    // Terminal compares use >= so a live shrink of prescale/period below the
    // running count wraps on the next step instead of overrunning.
    assign tick      = (presc_cnt >= prescale);
    assign wrap      = tick && (cnt >= period);
    assign wr_ch_ext = 32'(duty_bus.duty_wr_ch);
    assign wr_valid  = duty_bus.duty_wr_en && (wr_ch_ext < NUM_CH);

    // Prescaler: divides clk down to the PWM tick rate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= '0;
        end else if (tick) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

    // Period counter: advances once per tick and wraps at the period value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (tick) begin
            if (cnt >= period) begin
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Shadow duty registers take bus writes; out-of-range channels are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                shadow[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_valid && (wr_ch_ext == i)) begin
                    shadow[i] <= duty_bus.duty_wr_data;
                end
            end
        end
    end

    // Active duty reloads at wrap; a write landing on the wrap cycle bypasses
    // the shadow so the new value is not delayed by a whole period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                active[i] <= '0;
            end
        end else if (wrap) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wr_valid && (wr_ch_ext == i)) begin
                    active[i] <= duty_bus.duty_wr_data;
                end else begin
                    active[i] <= shadow[i];
                end
            end
        end
    end

    // Per-channel compare; an all-ones duty is high regardless of period.
    always_comb begin
        hi = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            hi[i] = (active[i] > cnt) || (active[i] == {CNT_W{1'b1}});
        end
    end

    // Registered output mux: output enable dominates, then PWM enable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!en_out[i]) begin
                    out[i] <= 1'b0;
                end else if (!en_pwm[i]) begin
                    out[i] <= 1'b1;
                end else begin
                    out[i] <= hi[i];
                end
            end
        end
    end

    // One-cycle pulse marking the start of each new PWM period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_start <= 1'b0;
        end else begin
            period_start <= wrap;
        end
    end

endmodule

// File: tb/tb_pwm_multichannel.sv
// Self-checking bench for pwm_multichannel: a cycle-level reference model
// pushes the expected outputs into a scoreboard each time stimulus is
// applied, and the entry is popped and compared once the DUT has clocked.
// Directed duty-cycle windows add fixed expected high/pulse counts.
module tb_pwm_multichannel;

    localparam int NUM_CH  = 16;
    localparam int CNT_W   = 8;
    localparam int PRESC_W = 4;

    logic                clk;
    logic                rst_n;
    logic [NUM_CH-1:0]   en_out;
    logic [NUM_CH-1:0]   en_pwm;
    logic [PRESC_W-1:0]  prescale;
    logic [CNT_W-1:0]    period;
    logic [NUM_CH-1:0]   out;
    logic                period_start;

    pwm_multichannel_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) duty_bus ();

    pwm_multichannel #(
        .NUM_CH  (NUM_CH),
        .CNT_W   (CNT_W),
        .PRESC_W (PRESC_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .duty_bus     (duty_bus),
        .en_out       (en_out),
        .en_pwm       (en_pwm),
        .prescale     (prescale),
        .period       (period),
        .out          (out),
        .period_start (period_start)
    );

    // 100 MHz clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    logic [NUM_CH:0] exp_q [$];
    int              cnt_q [$];

    logic [PRESC_W-1:0] m_presc;
    logic [CNT_W-1:0]   m_cnt;
    logic [CNT_W-1:0]   m_shadow [NUM_CH];
    logic [CNT_W-1:0]   m_active [NUM_CH];

    task automatic modelReset();
        m_presc = '0;
        m_cnt   = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
        end
    endtask

    // Predict the post-edge outputs from current state and inputs, push them,
    // advance the model, then let the DUT clock once.
    task automatic applyStimulus();
        logic [NUM_CH-1:0] e_out;
        logic              hi_bit;
        logic              m_tick;
        logic              m_wrap;
        logic              wr_ok;
        int                wr_ch;
        for (int i = 0; i < NUM_CH; i++) begin
            hi_bit   = (m_active[i] > m_cnt) || (m_active[i] == 8'hFF);
            e_out[i] = !en_out[i] ? 1'b0 : (!en_pwm[i] ? 1'b1 : hi_bit);
        end
        m_tick = (m_presc >= prescale);
        m_wrap = m_tick && (m_cnt >= period);
        exp_q.push_back({m_wrap, e_out});
        wr_ch = int'(duty_bus.duty_wr_ch);
        wr_ok = duty_bus.duty_wr_en && (wr_ch < NUM_CH);
        if (m_wrap) begin
            for (int i = 0; i < NUM_CH; i++) begin
                m_active[i] = (wr_ok && wr_ch == i) ? duty_bus.duty_wr_data : m_shadow[i];
            end
        end
        if (wr_ok) m_shadow[wr_ch] = duty_bus.duty_wr_data;
        if (m_tick) begin
            m_presc = '0;
            m_cnt   = (m_cnt >= period) ? '0 : m_cnt + 1'b1;
        end else begin
            m_presc = m_presc + 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        logic [NUM_CH:0] exp_v;
        exp_v = exp_q.pop_front();
        compared++;
        assert ({period_start, out} === exp_v) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed ps/out=%h expected=%h", tag, {period_start, out}, exp_v);
        end
    endtask

    task automatic stepCycle(input string tag);
        applyStimulus();
        checkOutput(tag);
    endtask

    task automatic checkCount(input string tag, input int observed);
        int exp_v;
        exp_v = cnt_q.pop_front();
        compared++;
        assert (observed === exp_v) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, exp_v);
        end
    endtask

    task automatic checkBit(input string tag, input logic observed, input logic expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    task automatic writeDuty(input int ch, input logic [CNT_W-1:0] data);
        duty_bus.duty_wr_en   = 1'b1;
        duty_bus.duty_wr_ch   = 4'(ch);
        duty_bus.duty_wr_data = data;
        stepCycle("duty_write");
        duty_bus.duty_wr_en   = 1'b0;
    endtask

    // Step until the DUT shows a period_start pulse; an expired budget fails.
    task automatic waitStart(input int budget);
        int k;
        k = 0;
        do begin
            stepCycle("wait_start");
            k++;
        end while (period_start !== 1'b1 && k < budget);
        checkBit("period_start_seen", period_start, 1'b1);
    endtask

    task automatic measureWindow(input int ch, input int n, output int highs, output int starts);
        highs  = 0;
        starts = 0;
        for (int k = 0; k < n; k++) begin
            stepCycle("window");
            highs  += int'(out[ch]);
            starts += int'(period_start);
        end
    endtask

    task automatic asyncReset();
        rst_n = 1'b0;
        #1;
        modelReset();
        checkBit("reset_out_zero", (out == '0), 1'b1);
        checkBit("reset_ps_zero", period_start, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int highs;
        int starts;
        int k;
        rst_n                 = 1'b0;
        en_out                = '0;
        en_pwm                = '0;
        prescale              = '0;
        period                = '0;
        duty_bus.duty_wr_en   = 1'b0;
        duty_bus.duty_wr_ch   = '0;
        duty_bus.duty_wr_data = '0;
        $display("[TB] start");

        // Power-on reset
        @(posedge clk);
        #1;
        asyncReset();

        // 50% duty at full period, no prescale
        en_out   = '1;
        en_pwm   = '1;
        prescale = 4'd0;
        period   = 8'd255;
        writeDuty(0, 8'd128);
        waitStart(600);
        cnt_q.push_back(128);
        cnt_q.push_back(1);
        measureWindow(0, 256, highs, starts);
        checkCount("ch0_high_128", highs);
        checkCount("ch0_period_256", starts);

        // Prescaled short period: 20 clk high, 40 clk period
        prescale = 4'd3;
        period   = 8'd9;
        writeDuty(1, 8'd5);
        waitStart(100);
        cnt_q.push_back(40);
        cnt_q.push_back(2);
        measureWindow(1, 80, highs, starts);
        checkCount("ch1_high_2x20", highs);
        checkCount("ch1_starts_2x40", starts);

        // Mid-period duty change takes effect only at the next wrap
        prescale = 4'd0;
        period   = 8'd255;
        writeDuty(2, 8'd64);
        waitStart(600);
        for (int i = 0; i < 100; i++) stepCycle("ch2_old_duty");
        writeDuty(2, 8'd192);
        waitStart(600);
        cnt_q.push_back(192);
        cnt_q.push_back(1);
        measureWindow(2, 256, highs, starts);
        checkCount("ch2_high_192", highs);
        checkCount("ch2_period", starts);

        // Write landing exactly on the wrap cycle bypasses the shadow
        k = 0;
        while (!(m_cnt >= period && m_presc >= prescale) && k < 600) begin
            stepCycle("to_wrap");
            k++;
        end
        writeDuty(6, 8'd77);
        checkBit("bypass_wrap_pulse", period_start, 1'b1);
        cnt_q.push_back(77);
        measureWindow(6, 256, highs, starts);
        checkCount("ch6_bypass_high_77", highs);

        // Duty extremes with period 99
        period = 8'd99;
        writeDuty(3, 8'd0);
        writeDuty(4, 8'hFF);
        writeDuty(5, 8'd150);
        waitStart(300);
        cnt_q.push_back(0);
        measureWindow(3, 100, highs, starts);
        checkCount("ch3_duty0_low", highs);
        cnt_q.push_back(100);
        measureWindow(4, 100, highs, starts);
        checkCount("ch4_dutyFF_high", highs);
        cnt_q.push_back(100);
        measureWindow(5, 100, highs, starts);
        checkCount("ch5_duty150_high", highs);

        // Enable handling
        en_out = '0;
        stepCycle("en_out_off");
        checkBit("all_off", (out == '0), 1'b1);
        en_out = '1;
        en_pwm = '0;
        stepCycle("static_high");
        checkBit("all_static_high", (out == '1), 1'b1);
        en_pwm = '1;
        for (int i = 0; i < 80; i++) begin
            en_out = NUM_CH'($urandom);
            en_pwm = NUM_CH'($urandom);
            stepCycle("enable_toggle");
        end
        en_out = '1;
        en_pwm = '1;

        // Random duty writes, periods and prescales
        for (int i = 0; i < 400; i++) begin
            if ((i % 50) == 0) begin
                period   = 8'($urandom_range(0, 20));
                prescale = 4'($urandom_range(0, 2));
            end
            duty_bus.duty_wr_en   = ($urandom_range(0, 3) == 0);
            duty_bus.duty_wr_ch   = 4'($urandom);
            duty_bus.duty_wr_data = 8'($urandom_range(0, 24));
            stepCycle("random");
        end
        duty_bus.duty_wr_en = 1'b0;

        // Reset mid-period while ch0 is high
        prescale = 4'd0;
        period   = 8'd255;
        writeDuty(0, 8'd128);
        waitStart(600);
        for (int i = 0; i < 10; i++) stepCycle("pre_reset");
        checkBit("ch0_high_before_reset", out[0], 1'b1);
        asyncReset();
        writeDuty(0, 8'd128);
        for (int i = 0; i < 20; i++) stepCycle("post_reset_low");
        checkBit("ch0_low_after_reset", out[0], 1'b0);
        waitStart(600);
        stepCycle("after_reload");
        checkBit("ch0_high_after_reload", out[0], 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
